prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that writes machine code into the instruction memory the fetch path later reads. It accepts a byte stream over a valid/ready handshake, assembles 9-bit instruction words and writes them to consecutive addresses from 0. When the last word is written it issues a one-cycle `start` pulse that kicks the processor's `Start` input.

## Interface

Parameters:
- `D`, 12, instruction address width; matches the program counter width.
- `W`, 9, instruction word width; fixed at 9 by the instruction format.

Ports:
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_data`  input  8  stream byte.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  loader can accept a byte this cycle.
- `reload`  input  1  restart the load sequence; honoured only in DONE or ERR.
- `wr_en`  output  1  instruction-memory write strobe.
- `wr_addr`  output  D  instruction-memory write address.
- `wr_data`  output  W  instruction word to write.
- `start`  output  1  one-cycle pulse when the program is fully written.
- `loaded`  output  1  level; high while in DONE.
- `err`  output  1  level; high while in ERR.

## Operation

- A byte is accepted on a rising edge where `in_valid && in_ready`. No other byte is consumed.
- Stream format:
  - Byte 0: word count high, as `count[D-1:8] = byte[D-9:0]`. Unused upper bits are ignored.
  - Byte 1: `count[7:0]`.
  - Then two bytes per word:
    - High byte: bit 0 is `mach_code[8]`. Bits 7:1 must be 0.
    - Low byte: `mach_code[7:0]`.
- FSM states: LEN_HI, LEN_LO, INS_HI, INS_LO, START, DONE, ERR.
  - LEN_HI: on accept → LEN_LO.
  - LEN_LO: on accept → INS_HI if count ≠ 0, otherwise → START.
  - INS_HI: on accept with bits 7:1 = 0 → INS_LO. With any of bits 7:1 set → ERR; nothing is written for that word.
  - INS_LO: on accept, write `{hi[0], lo}` at the current address and increment the address. → INS_HI if words remain, otherwise → START.
  - START: one cycle, `start` = 1, then → DONE.
  - DONE and ERR: hold until `reset`, or until `reload` = 1, which goes to LEN_HI and clears the address to 0.
- `in_ready` is 1 only in LEN_HI, LEN_LO, INS_HI and INS_LO. It does not depend on `in_valid`.
- Address counter:
  - D bits wide, starts at 0.
  - Count 2^D−1 is the maximum; the counter never wraps within a legal load.
  - Words already written before an ERR remain in memory.
- `reload` in any state other than DONE or ERR is ignored.

## Timing

- All outputs are registered.
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `start`=0, `loaded`=0, `err`=0.
  - State after reset: LEN_HI.
  - `in_ready` rises in the first cycle after `reset` deasserts.
- Write timing:
  - `wr_en` is high for exactly one cycle: the cycle after the INS_LO byte is accepted.
  - `wr_addr` and `wr_data` are valid in that cycle.
  - `wr_data`/`wr_addr` hold their last value when `wr_en` = 0.
- Throughput: maximum one byte per cycle, so one word every 2 cycles. Gaps in `in_valid` stall the FSM with no state loss.
- `start` is high in the cycle after the last `wr_en` cycle.
  - For count = 0, `start` is high in the cycle after LEN_LO is accepted.
  - `start` never coincides with `wr_en`.
- `loaded` rises the cycle after `start` and stays high until `reset` or `reload`.
- `err` rises the cycle after the offending high byte is accepted.
- Reset mid-load: all outputs return to their reset values immediately. Any in-flight partial word is discarded. A new load begins at address 0.
- `reload` taken in DONE or ERR: `loaded` and `err` clear and `in_ready` rises on the next cycle.

## Test plan

- Load count 3 with words `0x1A5`, `0x003`, `0x100` (bytes 00 03 01 A5 00 03 01 00), `in_valid` held high:
  - Required: `wr_en` at addresses 0, 1, 2 with those data values.
  - Required: `start` pulses once, one cycle after the address-2 write.
  - Required: `loaded` = 1 afterwards and `in_ready` = 0.
- Count 0 (bytes 00 00):
  - Required: no `wr_en`.
  - Required: `start` pulses the cycle after the second byte is accepted.
  - Required: `loaded` = 1.
- Count 2, second high byte = `0x02`:
  - Required: one write at address 0.
  - Required: `err` = 1, no `start`, `in_ready` = 0.
  - Then `reload` = 1 followed by a valid count-1 load: write at address 0, `start`, `err` = 0, `loaded` = 1.
- Same 3-word load with `in_valid` toggled randomly 50%:
  - Required: identical writes and order; no byte is dropped or duplicated.
  - Required: `wr_en` count = 3.
- Assert `reset` one cycle after the low byte of word 1 is accepted:
  - Required: all outputs are 0 within that cycle.
  - Required: a fresh count-1 load writes address 0.
- `reload` pulsed during INS_HI:
  - Required: it is ignored; the load completes normally.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The slave side is the loader; the master side feeds bytes and observes writes.
interface prog_loader_if #(
    parameter int D = 12,
    parameter int W = 9
);
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time loader: assembles 9-bit words from a byte stream, writes them
// from address 0 upward and pulses start once the whole program is in memory.
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic            clk,
    input  logic            reset,
    prog_loader_if.slave    bus,
    input  logic            reload,
    output logic            start,
    output logic            loaded,
    output logic            err
);
    localparam logic [2:0] LEN_HI = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] INS_HI = 3'd2;
    localparam logic [2:0] INS_LO = 3'd3;
    localparam logic [2:0] START  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [D-1:0] addr;
    logic [D-1:0] count;
    logic         hi_bit;
    logic         acc;
    logic         len_zero;
    logic         last;
    logic         hi_bad;
    logic         wr_fire;
    logic         take_reload;
    logic [W-1:0] word;

    assign acc         = bus.in_valid && bus.in_ready;
    assign len_zero    = ({count[D-1:8], bus.in_data} == '0);
    assign last        = ((addr + ONE) == count);
    assign hi_bad      = (bus.in_data[7:1] != 7'd0);
    assign wr_fire     = (state == INS_LO) && acc;
    assign word        = {hi_bit, bus.in_data};
    assign take_reload = reload && ((state == DONE) || (state == ERR));

    always_comb begin
        state_nxt = state;
        unique case (state)
            LEN_HI: begin
                if (acc)
                    state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (acc)
                    state_nxt = len_zero ? START : INS_HI;
            end
            INS_HI: begin
                if (acc)
                    state_nxt = hi_bad ? ERR : INS_LO;
            end
            INS_LO: begin
                if (acc)
                    state_nxt = last ? START : INS_HI;
            end
            // Linger while the final write is on the bus so start follows it.
            START: begin
                if (!bus.wr_en)
                    state_nxt = DONE;
            end
            DONE, ERR: begin
                if (reload)
                    state_nxt = LEN_HI;
            end
            default: state_nxt = LEN_HI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LEN_HI;
            addr         <= '0;
            count        <= '0;
            hi_bit       <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            start        <= 1'b0;
            loaded       <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.in_ready <= (state_nxt == LEN_HI) ||
                            (state_nxt == LEN_LO) ||
                            (state_nxt == INS_HI) ||
                            (state_nxt == INS_LO);
            bus.wr_en    <= wr_fire;
            start        <= (state_nxt == START) &&
                            (state != INS_LO);
            loaded       <= (state_nxt == DONE);
            err          <= (state_nxt == ERR);

            if ((state == LEN_HI) && acc)
                count[D-1:8] <= bus.in_data[D-9:0];
            if ((state == LEN_LO) && acc)
                count[7:0] <= bus.in_data;
            if ((state == INS_HI) && acc)
                hi_bit <= bus.in_data[0];

            if (wr_fire) begin
                bus.wr_addr <= addr;
                bus.wr_data <= word;
                addr        <= addr + ONE;
            end

            if (take_reload)
                addr <= '0;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed loads push expected writes and
// start events; a negedge monitor pops and compares them as they appear.
module tb_prog_loader;
    localparam int D = 12;
    localparam int W = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reload = 1'b0;
    logic start;
    logic loaded;
    logic err;

    prog_loader_if #(.D(D), .W(W)) bus();

    prog_loader #(.D(D), .W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .reload (reload),
        .start  (start),
        .loaded (loaded),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    int base_wr = 0;
    int base_start = 0;

    logic [D+W-1:0] exp_wr[$];
    bit             exp_start[$];
    logic [W-1:0]   words[4];

    bit             prev_wr = 1'b0;
    bit             prev_acc = 1'b0;
    logic [D+W-1:0] mon_e;
    bit             mon_t;
    bit             mon_ok;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: compares every write and start pulse against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_wr  = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (bus.wr_en) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr", {bus.wr_addr, bus.wr_data}, 0);
                    if ({bus.wr_addr, bus.wr_data} == 0)
                        chk("unexpected_wr_zero", 1, 0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr_data", {bus.wr_addr, bus.wr_data}, mon_e);
                end
            end
            if (start) begin
                start_cnt++;
                if (exp_start.size() == 0) begin
                    chk("unexpected_start", start, 0);
                end else begin
                    mon_t  = exp_start.pop_front();
                    mon_ok = mon_t ? prev_wr : prev_acc;
                    chk("start_timing", mon_ok, 1);
                    chk("start_vs_wr_en", bus.wr_en, 0);
                end
            end
            prev_wr  = bus.wr_en;
            prev_acc = bus.in_valid && bus.in_ready;
        end
    end

    task automatic send(input logic [7:0] b, input bit gaps);
        int n;
        bit rdy;
        if (gaps) begin
            while ($urandom_range(0, 1) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy)
            chk("accept_timeout", rdy, 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input bit gaps);
        base_wr    = wr_cnt;
        base_start = start_cnt;
        exp_start.push_back(n != 0);
        send(8'h00, gaps);
        send(n[7:0], gaps);
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({D'(i), words[i]});
            send({7'd0, words[i][8]}, gaps);
            send(words[i][7:0], gaps);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_done(input int n);
        idle(4);
        @(negedge clk);
        chk("loaded", loaded, 1);
        chk("in_ready_done", bus.in_ready, 0);
        chk("err_clear", err, 0);
        chk("wr_count", wr_cnt - base_wr, n);
        chk("start_count", start_cnt - base_start, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        @(negedge clk);
        chk("reload_loaded", loaded, 0);
        chk("reload_err", err, 0);
        chk("reload_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_loaded"}, loaded, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        check_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", bus.in_ready, 1);

        // Three words back to back.
        words[0] = 9'h1A5;
        words[1] = 9'h003;
        words[2] = 9'h100;
        load(3, 1'b0);
        check_done(3);
        do_reload();

        // Empty program.
        load(0, 1'b0);
        check_done(0);
        do_reload();

        // Bad high byte on the second word.
        base_wr    = wr_cnt;
        base_start = start_cnt;
        exp_wr.push_back({12'h000, 9'h011});
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'h11, 1'b0);
        send(8'h02, 1'b0);
        idle(3);
        @(negedge clk);
        chk("err_set", err, 1);
        chk("err_loaded", loaded, 0);
        chk("err_in_ready", bus.in_ready, 0);
        chk("err_start_count", start_cnt - base_start, 0);
        chk("err_wr_count", wr_cnt - base_wr, 1);
        @(posedge clk);
        #1;
        do_reload();
        words[0] = 9'h1FF;
        load(1, 1'b0);
        check_done(1);
        do_reload();

        // Same three words with random valid gaps.
        words[0] = 9'h1A5;
        words[1] = 9'h003;
        words[2] = 9'h100;
        load(3, 1'b1);
        check_done(3);
        do_reload();

        // Reset one cycle after word 1's low byte is accepted.
        exp_wr.push_back({12'h000, 9'h1A5});
        exp_wr.push_back({12'h001, 9'h003});
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h01, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        words[0] = 9'h0C3;
        load(1, 1'b0);
        check_done(1);
        do_reload();

        // Reload pulsed while waiting in INS_HI is ignored.
        base_wr    = wr_cnt;
        base_start = start_cnt;
        exp_start.push_back(1'b1);
        exp_wr.push_back({12'h000, 9'h0AA});
        exp_wr.push_back({12'h001, 9'h155});
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        bus.in_valid = 1'b0;
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        @(negedge clk);
        chk("reload_ign_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        send(8'h00, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h01, 1'b0);
        send(8'h55, 1'b0);
        bus.in_valid = 1'b0;
        check_done(2);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("start_queue_empty", exp_start.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
